// File: rtl/vx_ag_tcu_uop_seq.sv
// AG-TCU WMMA micro-op sequencer.
// Expands one WMMA into M*N*K (m,n,k) uops, k fastest.
module vx_ag_tcu_uop_seq #(
  parameter int M_STEPS  = 4,
  parameter int N_STEPS  = 4,
  parameter int K_STEPS  = 4,
  parameter int A_SUB    = 1,
  parameter int B_SUB    = 2,
  parameter int RA       = 0,
  parameter int RB       = 10,
  parameter int RC       = 24,
  parameter int REG_BITS = 6,
  parameter int TAG_W    = 16,
  localparam int MW = (M_STEPS > 1) ? $clog2(M_STEPS) : 1,
  localparam int NW = (N_STEPS > 1) ? $clog2(N_STEPS) : 1,
  localparam int KW = (K_STEPS > 1) ? $clog2(K_STEPS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_fmt_s,
  input  logic [3:0]          in_fmt_d,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [MW-1:0]       out_step_m,
  output logic [NW-1:0]       out_step_n,
  output logic [KW-1:0]       out_step_k,
  output logic [REG_BITS-1:0] out_rs1,
  output logic [REG_BITS-1:0] out_rs2,
  output logic [REG_BITS-1:0] out_rs3,
  output logic [3:0]          out_fmt_s,
  output logic [3:0]          out_fmt_d,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_first,
  output logic                out_last,
  output logic                err
);

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam logic [MW-1:0] M_MAX = MW'(M_STEPS - 1);
  localparam logic [NW-1:0] N_MAX = NW'(N_STEPS - 1);
  localparam logic [KW-1:0] K_MAX = KW'(K_STEPS - 1);

  state_t        state;
  logic [MW-1:0] m;
  logic [NW-1:0] n;
  logic [KW-1:0] k;
  logic          legal;
  logic          k_wrap;
  logic          n_wrap;

  assign legal = (in_fmt_d == 4'd8)
              && (in_fmt_s >= 4'd9)
              && (in_fmt_s <= 4'd12);

  assign k_wrap = (k == K_MAX);
  assign n_wrap = (n == N_MAX);

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == ISSUE);
  assign out_step_m = m;
  assign out_step_n = n;
  assign out_step_k = k;
  assign out_first  = (k == '0);
  assign out_last   = (m == M_MAX) && n_wrap && k_wrap;

  // Register indices derived from the current step counters
  always_comb begin
    out_rs1 = REG_BITS'(32'(RA)
            + (32'(m) * 32'(K_STEPS) + 32'(k)) / 32'(A_SUB));
    out_rs2 = REG_BITS'(32'(RB)
            + (32'(k) * 32'(N_STEPS) + 32'(n)) / 32'(B_SUB));
    out_rs3 = REG_BITS'(32'(RC)
            + 32'(m) * 32'(N_STEPS) + 32'(n));
  end

  // Accept/issue FSM with step counters and latched instruction fields
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      m         <= '0;
      n         <= '0;
      k         <= '0;
      out_fmt_s <= '0;
      out_fmt_d <= '0;
      out_tag   <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            out_fmt_s <= in_fmt_s;
            out_fmt_d <= in_fmt_d;
            out_tag   <= in_tag;
            m         <= '0;
            n         <= '0;
            k         <= '0;
            if (legal) state <= ISSUE;
            else       err   <= 1'b1;
          end
        end
        ISSUE: begin
          if (out_ready) begin
            if (out_last) state <= IDLE;
            if (k_wrap) begin
              k <= '0;
              if (n_wrap) begin
                n <= '0;
                m <= (m == M_MAX) ? '0 : m + MW'(1);
              end else begin
                n <= n + NW'(1);
              end
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vx_ag_tcu_uop_seq.sv
// Directed bench for the AG-TCU uop sequencer.
// Default geometry: 4x4x4, RA/RB/RC = 0/10/24.
module tb_vx_ag_tcu_uop_seq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_fmt_s;
  logic [3:0]  in_fmt_d;
  logic [15:0] in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_step_m;
  logic [1:0]  out_step_n;
  logic [1:0]  out_step_k;
  logic [5:0]  out_rs1;
  logic [5:0]  out_rs2;
  logic [5:0]  out_rs3;
  logic [3:0]  out_fmt_s;
  logic [3:0]  out_fmt_d;
  logic [15:0] out_tag;
  logic        out_first;
  logic        out_last;
  logic        err;

  int n_cmp;
  int n_bad;

  vx_ag_tcu_uop_seq dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fmt_s   (in_fmt_s),
    .in_fmt_d   (in_fmt_d),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_step_m (out_step_m),
    .out_step_n (out_step_n),
    .out_step_k (out_step_k),
    .out_rs1    (out_rs1),
    .out_rs2    (out_rs2),
    .out_rs3    (out_rs3),
    .out_fmt_s  (out_fmt_s),
    .out_fmt_d  (out_fmt_d),
    .out_tag    (out_tag),
    .out_first  (out_first),
    .out_last   (out_last),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consume uops, checking each against the (m,n,k) model
  task automatic run_batch(input logic [15:0] t,
                           input bit bp,
                           input int stop_at);
    int idx;
    int cyc;
    int m, n, k;
    logic [63:0] exp;
    logic [63:0] got;
    idx = 0;
    cyc = 0;
    while (idx < stop_at && cyc < 400) begin
      out_ready = bp ? cyc[0] : 1'b1;
      chk("valid", 64'(out_valid), 64'd1);
      if (out_valid) begin
        m = idx / 16;
        n = (idx / 4) % 4;
        k = idx % 4;
        exp = {34'd0,
               2'(m), 2'(n), 2'(k),
               6'(m * 4 + k),
               6'(10 + (k * 4 + n) / 2),
               6'(24 + m * 4 + n),
               (k == 0), (idx == 63)};
        got = {34'd0,
               out_step_m, out_step_n, out_step_k,
               out_rs1, out_rs2, out_rs3,
               out_first, out_last};
        chk("uop", got, exp);
        chk("tag", 64'(out_tag), 64'(t));
        if (idx == 0)
          chk("uop0_rs", 64'({out_rs1, out_rs2, out_rs3}),
              64'({6'd0, 6'd10, 6'd24}));
        if (idx == 4)
          chk("uop4_rs3", 64'(out_rs3), 64'd25);
        if (idx == 5 || idx == 9)
          chk("rs2_k1", 64'(out_rs2), (idx == 5) ? 64'd12 : 64'd13);
        if (idx == 63)
          chk("last_rs", 64'({out_rs1, out_rs2, out_rs3, out_last}),
              64'({6'd15, 6'd17, 6'd39, 1'b1}));
        if (out_ready) idx++;
      end
      tick();
      cyc++;
    end
    chk("batch_count", 64'(idx), 64'(stop_at));
  endtask

  task automatic start(input logic [3:0] fs,
                       input logic [3:0] fd,
                       input logic [15:0] t);
    in_valid = 1'b1;
    in_fmt_s = fs;
    in_fmt_d = fd;
    in_tag   = t;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_fmt_s  = 4'd0;
    in_fmt_d  = 4'd0;
    in_tag    = 16'd0;
    out_ready = 1'b1;
    repeat (2) tick();
    reset = 1'b0;

    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_latch", 64'({out_fmt_s, out_fmt_d, out_tag}), 64'd0);
    chk("rst_steps", 64'({out_step_m, out_step_n, out_step_k}), 64'd0);

    // legal I8->I32 at full throughput
    start(4'd9, 4'd8, 16'hA5A5);
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("fmt", 64'({out_fmt_s, out_fmt_d}), 64'h98);
    chk("busy_ready", 64'(in_ready), 64'd0);
    run_batch(16'hA5A5, 1'b0, 64);
    chk("end_valid", 64'(out_valid), 64'd0);
    chk("end_ready", 64'(in_ready), 64'd1);

    // backpressure
    start(4'd12, 4'd8, 16'h1234);
    run_batch(16'h1234, 1'b1, 64);
    chk("bp_end_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;

    // illegal format pair
    start(4'd12, 4'd9, 16'hBEEF);
    chk("ill_err", 64'(err), 64'd1);
    chk("ill_valid", 64'(out_valid), 64'd0);
    chk("ill_ready", 64'(in_ready), 64'd1);
    tick();
    chk("ill_err_clr", 64'(err), 64'd0);
    chk("ill_valid2", 64'(out_valid), 64'd0);

    // back-to-back with in_valid held
    start(4'd10, 4'd8, 16'h1111);
    in_valid = 1'b1;
    in_tag   = 16'h2222;
    run_batch(16'h1111, 1'b0, 64);
    chk("b2b_bubble", 64'(out_valid), 64'd0);
    chk("b2b_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    run_batch(16'h2222, 1'b0, 64);
    chk("b2b_end", 64'(out_valid), 64'd0);

    // reset mid-instruction at uop #20
    start(4'd11, 4'd8, 16'h3333);
    run_batch(16'h3333, 1'b0, 20);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_err", 64'(err), 64'd0);
    start(4'd9, 4'd8, 16'h4444);
    run_batch(16'h4444, 1'b0, 64);
    chk("restart_end", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
